// File: rtl/la_jtagctrl_pkg.sv
// Shared opcodes, FSM encoding and TMS sequence lengths for the JTAG host sequencer.
package la_jtagctrl_pkg;

    localparam logic [1:0] OP_RST = 2'b00;
    localparam logic [1:0] OP_IR  = 2'b01;
    localparam logic [1:0] OP_DR  = 2'b10;
    localparam logic [1:0] OP_RUN = 2'b11;

    // TCK cycles with TRST low / TMS high before the single TMS=0 cycle.
    localparam int RST_CYC = 5;
    // Idle -> Shift-IR (1,1,0,0) and Idle -> Shift-DR (1,0,0).
    localparam int HDR_IR  = 4;
    localparam int HDR_DR  = 3;
    // Exit1 -> Update -> Idle (1,0).
    localparam int TRL     = 2;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_IDLE,
        ST_RST,
        ST_HDR,
        ST_SHIFT,
        ST_TRL,
        ST_RUN,
        ST_RESP
    } state_t;

endpackage

// File: rtl/la_jtagctrl_tick.sv
// TCK divider: one tick every div+1 clk cycles while enabled, tck toggles per tick.
module la_jtagctrl_tick
    import la_jtagctrl_pkg::*;
#(
    parameter int DIVW = 8
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            en,
    input  logic [DIVW-1:0] div,
    output logic            rise_tick,
    output logic            fall_tick,
    output logic            tck
);

    logic [DIVW-1:0] cnt;
    logic            tick;

    assign tick      = en && (cnt == div);
    assign rise_tick = tick && !tck;
    assign fall_tick = tick && tck;

    // Divider counter and TCK phase; both park at 0 whenever disabled.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (tick) begin
            cnt <= '0;
            tck <= ~tck;
        end else begin
            cnt <= cnt + DIVW'(1);
        end
    end

endmodule

// File: rtl/la_jtagctrl.sv
// JTAG host sequencer: one command at a time, walks the target TAP, shifts TDI, captures TDO.
// Handshakes: a transfer happens on a clk edge where valid and ready are both high;
// resp_valid/resp_data stay stable until resp_ready, req_ready is only high in IDLE.
module la_jtagctrl
    import la_jtagctrl_pkg::*;
#(
    parameter int DW   = 64,
    parameter int LW   = $clog2(DW) + 1,
    parameter int DIVW = 8
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic [DIVW-1:0] div,
    input  logic            req_valid,
    input  logic [1:0]      req_op,
    input  logic [LW-1:0]   req_len,
    input  logic [DW-1:0]   req_data,
    output logic            req_ready,
    output logic            resp_valid,
    output logic [DW-1:0]   resp_data,
    input  logic            resp_ready,
    output logic            busy,
    output logic            jtag_tck_out,
    output logic            jtag_tms_out,
    output logic            jtag_tdi_out,
    output logic            jtag_trst_out,
    input  logic            jtag_tdo_in,
    output state_t          dbg_state
);

    state_t          state, state_next;
    logic [LW-1:0]   cnt, cnt_next;
    logic [1:0]      op_q, op_n;
    logic [LW-1:0]   len_q, len_n;
    logic [DW-1:0]   data_q, data_n, data_sh;
    logic [DIVW-1:0] div_q, div_n, tick_div;
    logic [DW-1:0]   cap_q;
    logic [LW-1:0]   hdr_last;
    logic            tms_n, tdi_n, trst_n;
    logic            accept, tick_en, rise_tick, fall_tick;

    assign accept     = (state == ST_IDLE) && req_valid;
    assign tick_en    = (state != ST_IDLE) && (state != ST_RESP);
    // BOOT has no accepted command, so it follows the live divider input.
    assign tick_div   = (state == ST_BOOT) ? div : div_q;
    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign busy       = (state != ST_IDLE);
    assign resp_data  = cap_q;
    assign dbg_state  = state;

    la_jtagctrl_tick #(.DIVW(DIVW)) u_tick (
        .clk       (clk),
        .nreset    (nreset),
        .en        (tick_en),
        .div       (tick_div),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .tck       (jtag_tck_out)
    );

    // Next state, phase counter, command latch, and the pin values for the next TCK cycle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        op_n       = op_q;
        len_n      = len_q;
        data_n     = data_q;
        div_n      = div_q;
        hdr_last   = (op_q == OP_IR) ? LW'(HDR_IR - 1) : LW'(HDR_DR - 1);
        case (state)
            ST_BOOT, ST_RST: if (fall_tick) begin
                if (cnt == LW'(RST_CYC)) begin
                    state_next = (state == ST_BOOT) ? ST_IDLE : ST_RESP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + LW'(1);
                end
            end
            ST_IDLE: if (req_valid) begin
                op_n     = req_op;
                len_n    = (req_len > LW'(DW)) ? LW'(DW) : req_len;
                data_n   = req_data;
                div_n    = div;
                cnt_next = '0;
                if (req_op == OP_RST)      state_next = ST_RST;
                else if (len_n == '0)      state_next = ST_RESP;
                else if (req_op == OP_RUN) state_next = ST_RUN;
                else                       state_next = ST_HDR;
            end
            ST_HDR: if (fall_tick) begin
                if (cnt == hdr_last) begin
                    state_next = ST_SHIFT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + LW'(1);
                end
            end
            ST_SHIFT: if (fall_tick) begin
                if (cnt == len_q - LW'(1)) begin
                    state_next = ST_TRL;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + LW'(1);
                end
            end
            ST_TRL: if (fall_tick) begin
                if (cnt == LW'(TRL - 1)) begin
                    state_next = ST_RESP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + LW'(1);
                end
            end
            ST_RUN: if (fall_tick) begin
                if (cnt == len_q - LW'(1)) begin
                    state_next = ST_RESP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + LW'(1);
                end
            end
            ST_RESP: if (resp_ready) state_next = ST_IDLE;
            default: state_next = ST_BOOT;
        endcase

        // Pins are a pure function of the upcoming (state, cnt), so they only change
        // at acceptance or on a falling tick.
        tms_n   = 1'b0;
        tdi_n   = 1'b0;
        trst_n  = 1'b1;
        data_sh = data_n >> cnt_next;
        case (state_next)
            ST_BOOT, ST_RST: begin
                trst_n = (cnt_next == LW'(RST_CYC));
                tms_n  = (cnt_next <  LW'(RST_CYC));
            end
            ST_HDR:   tms_n = (op_n == OP_IR) ? (cnt_next < LW'(HDR_IR - 2))
                                              : (cnt_next < LW'(HDR_DR - 2));
            ST_SHIFT: begin
                tms_n = (cnt_next == len_n - LW'(1));
                tdi_n = data_sh[0];
            end
            ST_TRL:   tms_n = (cnt_next == '0);
            default:  tms_n = 1'b0;
        endcase
    end

    // FSM state, phase counter and registered pin drives.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state         <= ST_BOOT;
            cnt           <= '0;
            jtag_tms_out  <= 1'b1;
            jtag_tdi_out  <= 1'b0;
            jtag_trst_out <= 1'b1;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            jtag_tms_out  <= tms_n;
            jtag_tdi_out  <= tdi_n;
            jtag_trst_out <= trst_n;
        end
    end

    // Command latch and TDO capture; capture is cleared at acceptance so non-scan ops return 0.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            op_q   <= OP_RST;
            len_q  <= '0;
            data_q <= '0;
            div_q  <= DIVW'(1);
            cap_q  <= '0;
        end else begin
            op_q   <= op_n;
            len_q  <= len_n;
            data_q <= data_n;
            div_q  <= div_n;
            if (accept)
                cap_q <= '0;
            else if (state == ST_SHIFT && rise_tick)
                cap_q <= cap_q | (DW'(jtag_tdo_in) << cnt);
        end
    end

endmodule

// File: tb/tb_la_jtagctrl.sv
// Directed bench for la_jtagctrl with a behavioural TAP (5-bit IR, 32-bit loopback DR).
module tb_la_jtagctrl;
    import la_jtagctrl_pkg::*;

    localparam int DW   = 64;
    localparam int LW   = 7;
    localparam int DIVW = 8;

    // ---------------- clock / reset ----------------
    logic            clk = 1'b0;
    logic            nreset;
    logic [DIVW-1:0] div;
    logic            req_valid;
    logic [1:0]      req_op;
    logic [LW-1:0]   req_len;
    logic [DW-1:0]   req_data;
    logic            req_ready;
    logic            resp_valid;
    logic [DW-1:0]   resp_data;
    logic            resp_ready;
    logic            busy;
    logic            jtag_tck_out, jtag_tms_out, jtag_tdi_out, jtag_trst_out;
    logic            jtag_tdo_in;
    state_t          dbg_state;

    always #5 clk = ~clk;

    la_jtagctrl #(.DW(DW), .LW(LW), .DIVW(DIVW)) dut (
        .clk           (clk),
        .nreset        (nreset),
        .div           (div),
        .req_valid     (req_valid),
        .req_op        (req_op),
        .req_len       (req_len),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .resp_ready    (resp_ready),
        .busy          (busy),
        .jtag_tck_out  (jtag_tck_out),
        .jtag_tms_out  (jtag_tms_out),
        .jtag_tdi_out  (jtag_tdi_out),
        .jtag_trst_out (jtag_trst_out),
        .jtag_tdo_in   (jtag_tdo_in),
        .dbg_state     (dbg_state)
    );

    // ---------------- target TAP model ----------------
    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
    } tap_t;

    tap_t        tap = TLR;
    logic [31:0] dr = 32'h12345678;
    logic [31:0] dr_sr = '0;
    logic [4:0]  ir = 5'h1f;
    logic [4:0]  ir_sr = '0;
    logic        tdo = 1'b0;

    function automatic tap_t tap_next(input tap_t s, input logic tms);
        case (s)
            TLR:    return tms ? TLR    : RTI;
            RTI:    return tms ? SEL_DR : RTI;
            SEL_DR: return tms ? SEL_IR : CAP_DR;
            CAP_DR: return tms ? EX1_DR : SH_DR;
            SH_DR:  return tms ? EX1_DR : SH_DR;
            EX1_DR: return tms ? UPD_DR : PA_DR;
            PA_DR:  return tms ? EX2_DR : PA_DR;
            EX2_DR: return tms ? UPD_DR : SH_DR;
            UPD_DR: return tms ? SEL_DR : RTI;
            SEL_IR: return tms ? TLR    : CAP_IR;
            CAP_IR: return tms ? EX1_IR : SH_IR;
            SH_IR:  return tms ? EX1_IR : SH_IR;
            EX1_IR: return tms ? UPD_IR : PA_IR;
            PA_IR:  return tms ? EX2_IR : PA_IR;
            EX2_IR: return tms ? UPD_IR : SH_IR;
            default: return tms ? SEL_DR : RTI;
        endcase
    endfunction

    always @(posedge jtag_tck_out or negedge jtag_trst_out) begin
        if (!jtag_trst_out) begin
            tap <= TLR;
        end else begin
            case (tap)
                CAP_DR: dr_sr <= dr;
                SH_DR:  dr_sr <= {jtag_tdi_out, dr_sr[31:1]};
                UPD_DR: dr    <= dr_sr;
                CAP_IR: ir_sr <= 5'b00001;
                SH_IR:  ir_sr <= {jtag_tdi_out, ir_sr[4:1]};
                UPD_IR: ir    <= ir_sr;
                default: ;
            endcase
            tap <= tap_next(tap, jtag_tms_out);
        end
    end

    always @(negedge jtag_tck_out)
        tdo <= (tap == SH_DR) ? dr_sr[0] : (tap == SH_IR) ? ir_sr[0] : 1'b0;

    assign jtag_tdo_in = tdo;

    // Pin values seen at every TCK rising edge.
    logic tms_hist  [0:4095];
    logic tdi_hist  [0:4095];
    logic trst_hist [0:4095];
    int   rise_cnt = 0;

    always @(posedge jtag_tck_out) begin
        tms_hist[rise_cnt]  <= jtag_tms_out;
        tdi_hist[rise_cnt]  <= jtag_tdi_out;
        trst_hist[rise_cnt] <= jtag_trst_out;
        rise_cnt            <= rise_cnt + 1;
    end

    function automatic logic [15:0] tms_bits(input int start, input int n);
        logic [15:0] v = '0;
        for (int i = 0; i < n && i < 16; i++) v[i] = tms_hist[start + i];
        return v;
    endfunction

    function automatic logic [15:0] tdi_bits(input int start, input int n);
        logic [15:0] v = '0;
        for (int i = 0; i < n && i < 16; i++) v[i] = tdi_hist[start + i];
        return v;
    endfunction

    function automatic logic [15:0] trst_bits(input int start, input int n);
        logic [15:0] v = '0;
        for (int i = 0; i < n && i < 16; i++) v[i] = trst_hist[start + i];
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- driver tasks ----------------
    // Issue one command, wait for its response, consume it. lat counts clk edges
    // from the acceptance edge to the first cycle with resp_valid high.
    task automatic send_cmd(input logic [1:0] op, input logic [LW-1:0] len,
                            input logic [DW-1:0] data, output logic [DW-1:0] resp,
                            output int lat);
        int t = 0;
        while (req_ready !== 1'b1 && t < 2000) begin @(posedge clk); #1; t++; end
        req_valid = 1'b1; req_op = op; req_len = len; req_data = data;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 20000) begin @(posedge clk); #1; lat++; end
        resp = resp_data;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (jtag_tck_out !== 1'b0) $display("FAIL reset_tck got %b exp 0", jtag_tck_out); else n_pass++;
        n_checks++; if (jtag_tms_out !== 1'b1) $display("FAIL reset_tms got %b exp 1", jtag_tms_out); else n_pass++;
        n_checks++; if (jtag_tdi_out !== 1'b0) $display("FAIL reset_tdi got %b exp 0", jtag_tdi_out); else n_pass++;
        n_checks++; if (jtag_trst_out !== 1'b1) $display("FAIL reset_trst got %b exp 1", jtag_trst_out); else n_pass++;
        n_checks++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready got %b exp 0", req_ready); else n_pass++;
        n_checks++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b exp 0", resp_valid); else n_pass++;
        n_checks++; if (resp_data !== '0) $display("FAIL reset_resp_data got %h exp 0", resp_data); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL reset_busy got %b exp 1", busy); else n_pass++;
        n_checks++; if (dbg_state !== ST_BOOT) $display("FAIL reset_state got %0d exp %0d", dbg_state, ST_BOOT); else n_pass++;
    endtask

    task automatic test_boot(input string tag);
        int start, cyc;
        @(posedge clk); #1;
        start  = rise_cnt;
        nreset = 1'b1;
        cyc    = 0;
        while (req_ready !== 1'b1 && cyc < 500) begin @(posedge clk); #1; cyc++; end
        n_checks++; if (cyc !== 24) $display("FAIL %s_latency got %0d exp 24", tag, cyc); else n_pass++;
        n_checks++; if (rise_cnt - start !== 6) $display("FAIL %s_rises got %0d exp 6", tag, rise_cnt - start); else n_pass++;
        n_checks++; if (tms_bits(start, 6) !== 16'h001f) $display("FAIL %s_tms got %h exp 001f", tag, tms_bits(start, 6)); else n_pass++;
        n_checks++; if (trst_bits(start, 6) !== 16'h0020) $display("FAIL %s_trst got %h exp 0020", tag, trst_bits(start, 6)); else n_pass++;
        n_checks++; if (tap !== RTI) $display("FAIL %s_tap got %0d exp %0d", tag, tap, RTI); else n_pass++;
        n_checks++; if (busy !== 1'b0 || dbg_state !== ST_IDLE) $display("FAIL %s_idle got busy=%b state=%0d exp busy=0 state=%0d", tag, busy, dbg_state, ST_IDLE); else n_pass++;
        n_checks++; if (jtag_tms_out !== 1'b0) $display("FAIL %s_tms_idle got %b exp 0", tag, jtag_tms_out); else n_pass++;
    endtask

    task automatic test_ir_scan();
        logic [DW-1:0] r; int lat, start;
        start = rise_cnt;
        send_cmd(OP_IR, 7'd5, 64'h15, r, lat);
        n_checks++; if (r !== 64'h01) $display("FAIL ir_resp got %h exp 01", r); else n_pass++;
        n_checks++; if (lat !== 44) $display("FAIL ir_latency got %0d exp 44", lat); else n_pass++;
        n_checks++; if (rise_cnt - start !== 11) $display("FAIL ir_rises got %0d exp 11", rise_cnt - start); else n_pass++;
        n_checks++; if (tms_bits(start, 11) !== 16'h0303) $display("FAIL ir_tms got %h exp 0303", tms_bits(start, 11)); else n_pass++;
        n_checks++; if (tdi_bits(start, 11) !== 16'h0150) $display("FAIL ir_tdi got %h exp 0150", tdi_bits(start, 11)); else n_pass++;
        n_checks++; if (ir !== 5'h15) $display("FAIL ir_update got %h exp 15", ir); else n_pass++;
        n_checks++; if (tap !== RTI) $display("FAIL ir_tap_end got %0d exp %0d", tap, RTI); else n_pass++;
    endtask

    task automatic test_dr_scan();
        logic [DW-1:0] r, e; int lat;
        exp_q.push_back(64'h12345678);
        exp_q.push_back(64'hDEADBEEF);
        for (int i = 0; i < 2; i++) begin
            send_cmd(OP_DR, 7'd32, 64'hDEADBEEF, r, lat);
            e = exp_q.pop_front();
            n_checks++; if (r !== e) $display("FAIL dr_resp%0d got %h exp %h", i, r, e); else n_pass++;
            n_checks++; if (lat !== 148) $display("FAIL dr_latency%0d got %0d exp 148", i, lat); else n_pass++;
        end
    endtask

    task automatic test_len_edges();
        logic [DW-1:0] r; int lat, start;
        start = rise_cnt;
        send_cmd(OP_DR, 7'd0, 64'hFFFF_FFFF_FFFF_FFFF, r, lat);
        n_checks++; if (r !== '0) $display("FAIL len0_resp got %h exp 0", r); else n_pass++;
        n_checks++; if (lat !== 0) $display("FAIL len0_latency got %0d exp 0", lat); else n_pass++;
        n_checks++; if (rise_cnt - start !== 0) $display("FAIL len0_rises got %0d exp 0", rise_cnt - start); else n_pass++;
        // Full-width scan through the 32-bit DR: old DR content, then the low half of TDI.
        send_cmd(OP_DR, 7'd64, 64'h0123456789ABCDEF, r, lat);
        n_checks++; if (r !== 64'h89ABCDEF_DEADBEEF) $display("FAIL lendw_resp got %h exp 89abcdefdeadbeef", r); else n_pass++;
        n_checks++; if (lat !== 276) $display("FAIL lendw_latency got %0d exp 276", lat); else n_pass++;
        send_cmd(OP_DR, 7'd71, 64'hFEDCBA9876543210, r, lat);
        n_checks++; if (r !== 64'h76543210_01234567) $display("FAIL lenclamp_resp got %h exp 7654321001234567", r); else n_pass++;
        n_checks++; if (lat !== 276) $display("FAIL lenclamp_latency got %0d exp 276", lat); else n_pass++;
        n_checks++; if (dr !== 32'hFEDCBA98) $display("FAIL lenclamp_dr got %h exp fedcba98", dr); else n_pass++;
    endtask

    task automatic test_run_and_rst();
        logic [DW-1:0] r; int lat, start;
        div   = 8'd3;
        start = rise_cnt;
        send_cmd(OP_RUN, 7'd5, 64'hFFFF, r, lat);
        n_checks++; if (r !== '0) $display("FAIL run_resp got %h exp 0", r); else n_pass++;
        n_checks++; if (lat !== 40) $display("FAIL run_latency got %0d exp 40", lat); else n_pass++;
        n_checks++; if (tms_bits(start, 5) !== 16'h0 || tdi_bits(start, 5) !== 16'h0 || rise_cnt - start !== 5)
            $display("FAIL run_pins got tms=%h tdi=%h rises=%0d exp 0 0 5", tms_bits(start, 5), tdi_bits(start, 5), rise_cnt - start);
        else n_pass++;
        div   = 8'd1;
        start = rise_cnt;
        send_cmd(OP_RST, 7'd9, 64'h1, r, lat);
        n_checks++; if (r !== '0) $display("FAIL rst_resp got %h exp 0", r); else n_pass++;
        n_checks++; if (lat !== 24) $display("FAIL rst_latency got %0d exp 24", lat); else n_pass++;
        n_checks++; if (trst_bits(start, 6) !== 16'h0020 || tms_bits(start, 6) !== 16'h001f)
            $display("FAIL rst_pins got trst=%h tms=%h exp 0020 001f", trst_bits(start, 6), tms_bits(start, 6));
        else n_pass++;
        n_checks++; if (tap !== RTI) $display("FAIL rst_tap got %0d exp %0d", tap, RTI); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] r; int t, bad, lat;
        t = 0;
        while (req_ready !== 1'b1 && t < 2000) begin @(posedge clk); #1; t++; end
        req_valid = 1'b1; req_op = OP_DR; req_len = 7'd32; req_data = 64'hCAFEF00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        t = 0;
        while (resp_valid !== 1'b1 && t < 20000) begin @(posedge clk); #1; t++; end
        n_checks++; if (resp_data !== 64'hFEDCBA98) $display("FAIL bp_resp got %h exp fedcba98", resp_data); else n_pass++;
        // A competing request while the response is held must be ignored.
        req_valid = 1'b1; req_op = OP_RUN; req_len = 7'd2; req_data = '0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (resp_valid !== 1'b1 || resp_data !== 64'hFEDCBA98 || req_ready !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL bp_hold got %0d bad cycles exp 0", bad); else n_pass++;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL bp_release got valid=%b ready=%b exp 0 1", resp_valid, req_ready); else n_pass++;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_checks++; if (req_ready !== 1'b0 || dbg_state !== ST_RUN) $display("FAIL bp_accept got ready=%b state=%0d exp 0 %0d", req_ready, dbg_state, ST_RUN); else n_pass++;
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 20000) begin @(posedge clk); #1; lat++; end
        n_checks++; if (lat !== 8 || resp_data !== '0) $display("FAIL bp_next got lat=%0d data=%h exp 8 0", lat, resp_data); else n_pass++;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [DW-1:0] r; int t, lat;
        t = 0;
        while (req_ready !== 1'b1 && t < 2000) begin @(posedge clk); #1; t++; end
        req_valid = 1'b1; req_op = OP_DR; req_len = 7'd32; req_data = 64'h0BADC0DE;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        n_checks++; if (dbg_state !== ST_SHIFT) $display("FAIL mid_in_shift got %0d exp %0d", dbg_state, ST_SHIFT); else n_pass++;
        nreset = 1'b0;
        #1;
        n_checks++; if (jtag_tck_out !== 1'b0 || jtag_tms_out !== 1'b1 || jtag_tdi_out !== 1'b0 || jtag_trst_out !== 1'b1)
            $display("FAIL mid_pins got tck=%b tms=%b tdi=%b trst=%b exp 0 1 0 1", jtag_tck_out, jtag_tms_out, jtag_tdi_out, jtag_trst_out);
        else n_pass++;
        n_checks++; if (busy !== 1'b1 || req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_data !== '0 || dbg_state !== ST_BOOT)
            $display("FAIL mid_ctrl got busy=%b ready=%b valid=%b data=%h state=%0d exp 1 0 0 0 %0d", busy, req_ready, resp_valid, resp_data, dbg_state, ST_BOOT);
        else n_pass++;
        repeat (3) @(posedge clk);
        test_boot("reboot");
        send_cmd(OP_DR, 7'd32, 64'h13579BDF, r, lat);
        n_checks++; if (r !== 64'hCAFEF00D) $display("FAIL mid_next_resp got %h exp cafef00d", r); else n_pass++;
        n_checks++; if (lat !== 148) $display("FAIL mid_next_latency got %0d exp 148", lat); else n_pass++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        nreset     = 1'b0;
        div        = 8'd1;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_len    = '0;
        req_data   = '0;
        resp_ready = 1'b0;
        test_reset();
        test_boot("boot");
        test_ir_scan();
        test_dr_scan();
        test_len_edges();
        test_run_and_rst();
        test_backpressure();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
